// File: rtl/reg_file_responder_if.sv
// Register-file access bus: two read ports, one write port, READ/WRITE strobes
// and the responder's READY/BUSY/RVALID status.
interface reg_file_responder_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
);
    logic                  read;
    logic                  write;
    logic [ADDR_WIDTH-1:0] addrR1;
    logic [ADDR_WIDTH-1:0] addrR2;
    logic [ADDR_WIDTH-1:0] addrW;
    logic [DATA_WIDTH-1:0] dataW;
    logic [DATA_WIDTH-1:0] dataR1;
    logic [DATA_WIDTH-1:0] dataR2;
    logic                  rvalid;
    logic                  ready;
    logic                  busy;

    modport master (
        output read, write, addrR1, addrR2, addrW, dataW,
        input  dataR1, dataR2, rvalid, ready, busy
    );

    modport slave (
        input  read, write, addrR1, addrR2, addrW, dataW,
        output dataR1, dataR2, rvalid, ready, busy
    );
endinterface

// File: rtl/reg_file_responder.sv
// Register-file responder: clears every entry after reset, then serves 2 registered reads + 1 write.
// Optional macro RF_BYPASS_EN enables write-before-read forwarding on a same-address collision.
module reg_file_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int DEPTH      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    reg_file_responder_if.slave  bus
);
    typedef enum logic { CLEAR, IDLE } state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] clrPtr_q;
    logic [ADDR_WIDTH-1:0] clrPtr_d;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] dataR1_q;
    logic [DATA_WIDTH-1:0] dataR2_q;
    logic [DATA_WIDTH-1:0] dataR1_d;
    logic [DATA_WIDTH-1:0] dataR2_d;
    logic                  rvalid_q;
    logic                  ready_q;
    logic                  busy_q;
    logic                  memWe;
    logic [ADDR_WIDTH-1:0] memAddr;
    logic [DATA_WIDTH-1:0] memData;

    assign clrPtr_d = clrPtr_q + ADDR_WIDTH'(1);

    // The single memory write port is shared by the clear sequencer and the bus write.
    always_comb begin
        memWe   = 1'b0;
        memAddr = bus.addrW;
        memData = bus.dataW;
        if (!rst_i) begin
            if (state_q == CLEAR) begin
                memWe   = 1'b1;
                memAddr = clrPtr_q;
                memData = '0;
            end else if (bus.write) begin
                memWe = 1'b1;
            end
        end
    end

    always_comb begin
        dataR1_d = mem_q[bus.addrR1];
        dataR2_d = mem_q[bus.addrR2];
`ifdef RF_BYPASS_EN
        if (bus.write && (bus.addrW == bus.addrR1)) dataR1_d = bus.dataW;
        if (bus.write && (bus.addrW == bus.addrR2)) dataR2_d = bus.dataW;
`endif
    end

    always_ff @(posedge clk_i) begin
        if (memWe) mem_q[memAddr] <= memData;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= CLEAR;
            clrPtr_q <= '0;
            dataR1_q <= '0;
            dataR2_q <= '0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
        end else begin
            case (state_q)
                CLEAR: begin
                    clrPtr_q <= clrPtr_d;
                    rvalid_q <= 1'b0;
                    if (clrPtr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                IDLE: begin
                    rvalid_q <= bus.read;
                    if (bus.read) begin
                        dataR1_q <= dataR1_d;
                        dataR2_q <= dataR2_d;
                    end
                end
                default: begin
                    state_q <= CLEAR;
                    clrPtr_q <= '0;
                end
            endcase
        end
    end

    assign bus.dataR1 = dataR1_q;
    assign bus.dataR2 = dataR2_q;
    assign bus.rvalid = rvalid_q;
    assign bus.ready  = ready_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_reg_file_responder.sv
// Randomized self-checking bench for reg_file_responder against an array-based reference model.
// Honours RF_BYPASS_EN to pick the expected collision behaviour.
module tb_reg_file_responder;
    localparam int DEPTH = 32;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   cycles;

    logic [31:0] modelMem [DEPTH];
    int          clearLeft;
    logic [31:0] expR1;
    logic [31:0] expR2;
    bit          expV;

    reg_file_responder_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) bus ();

    reg_file_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .DEPTH(DEPTH)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Drive one cycle of inputs, advance the reference model by one edge, then compare.
    task automatic applyStimulus(input bit r, input bit rd, input bit wr, input int a1, input int a2,
                                 input int aw, input logic [31:0] dw);
        rst         = r;
        bus.read    = rd;
        bus.write   = wr;
        bus.addrR1  = 5'(a1);
        bus.addrR2  = 5'(a2);
        bus.addrW   = 5'(aw);
        bus.dataW   = dw;
        @(posedge clk);
        if (r) begin
            clearLeft = DEPTH;
            expV      = 1'b0;
            expR1     = '0;
            expR2     = '0;
            for (int i = 0; i < DEPTH; i++) modelMem[i] = '0;
        end else if (clearLeft > 0) begin
            clearLeft--;
            expV = 1'b0;
        end else begin
            expV = rd;
            if (rd) begin
                expR1 = (BYP && wr && aw == a1) ? dw : modelMem[a1];
                expR2 = (BYP && wr && aw == a2) ? dw : modelMem[a2];
            end
            if (wr) modelMem[aw] = dw;
        end
        #1;
        checkOutput("ready",  32'(bus.ready),  32'(clearLeft == 0));
        checkOutput("busy",   32'(bus.busy),   32'(clearLeft != 0));
        checkOutput("rvalid", 32'(bus.rvalid), 32'(expV));
        checkOutput("dataR1", bus.dataR1, expR1);
        checkOutput("dataR2", bus.dataR2, expR2);
        @(negedge clk);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'b0, 0, 0, 0, 32'h0);
    endtask

    task automatic countClear();
        cycles = 0;
        do begin
            if (cycles == 3)
                applyStimulus(1'b0, 1'b1, 1'b1, 5, 5, 5, 32'hDEADBEEF);
            else
                applyStimulus(1'b0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 31)),
                              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), $urandom);
            cycles++;
        end while (!bus.ready && cycles < 100);
        checkOutput("clearLen", 32'(cycles), 32'd32);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        clearLeft = DEPTH;
        expV      = 1'b0;
        expR1     = '0;
        expR2     = '0;
        rst       = 1'b1;
        bus.read  = 1'b0;
        bus.write = 1'b0;
        bus.addrR1 = '0;
        bus.addrR2 = '0;
        bus.addrW  = '0;
        bus.dataW  = '0;
        @(negedge clk);

        // Reset, clear length, dropped accesses, and all-zero contents afterwards.
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h0);
        countClear();
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, i, DEPTH - 1 - i, 0, 32'h0);
            if (i == 5) checkOutput("dropWrite", bus.dataR1, 32'h0);
        end

        // Write every entry with its index, then read it back on both ports.
        for (int i = 0; i < DEPTH; i++) applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, i, 32'(i));
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, i, i, 0, 32'h0);
            checkOutput("wbR2", bus.dataR2, 32'(i));
        end

        // Same-address read/write collision.
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 7, 32'h11);
        applyStimulus(1'b0, 1'b1, 1'b1, 7, 7, 7, 32'h22);
        checkOutput("collide", bus.dataR1, BYP ? 32'h22 : 32'h11);
        applyStimulus(1'b0, 1'b1, 1'b0, 7, 7, 0, 32'h0);
        checkOutput("afterCollide", bus.dataR1, 32'h22);

        // Dual-port read then hold with READ low.
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 3, 32'd3);
        applyStimulus(1'b0, 1'b0, 1'b1, 0, 0, 30, 32'd30);
        applyStimulus(1'b0, 1'b1, 1'b0, 3, 30, 0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            idle();
            checkOutput("holdR1", bus.dataR1, 32'd3);
            checkOutput("holdR2", bus.dataR2, 32'd30);
        end

        // Reset while the clear pointer sits at 10.
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h0);
        for (int i = 0; i < 10; i++) idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 0, 0, 0, 32'h0);
        countClear();

        // Random traffic with narrow addresses for frequent collisions and rare resets.
        for (int n = 0; n < 600; n++) begin
            int hi;
            hi = ($urandom_range(0, 3) == 0) ? 3 : 31;
            applyStimulus(($urandom_range(0, 199) == 0), 1'($urandom), 1'($urandom),
                          int'($urandom_range(0, hi)), int'($urandom_range(0, hi)),
                          int'($urandom_range(0, hi)), $urandom);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
